// File: rtl/umi_regif_arb_if.sv
// rtl/umi_regif_arb_if.sv - UMI request/response port bundle used by umi_regif_arb
//
// Purpose: groups the valid/ready handshakes and field buses of one UMI
// port (or of NP ports side by side) into a single interface.
//
// Parameters: NP (number of ports carried), CW/AW/DW (cmd/addr/data widths).
// Request fields are NP-wide, packed with port i at [i*W +: W].
// Response fields are a single broadcast copy; only resp_valid/resp_ready
// are per-port.
//
// Modports:
//   master - the side that issues requests and consumes responses
//   slave  - the side that accepts requests and produces responses
interface umi_regif_arb_if #(
  parameter int NP = 1,
  parameter int CW = 32,
  parameter int AW = 64,
  parameter int DW = 256
);
  logic [NP-1:0]    req_valid;
  logic [NP*CW-1:0] req_cmd;
  logic [NP*AW-1:0] req_dstaddr;
  logic [NP*AW-1:0] req_srcaddr;
  logic [NP*DW-1:0] req_data;
  logic [NP-1:0]    req_ready;

  logic [NP-1:0]    resp_valid;
  logic [CW-1:0]    resp_cmd;
  logic [AW-1:0]    resp_dstaddr;
  logic [AW-1:0]    resp_srcaddr;
  logic [DW-1:0]    resp_data;
  logic [NP-1:0]    resp_ready;

  modport master (
    output req_valid, req_cmd, req_dstaddr, req_srcaddr, req_data,
    input  req_ready,
    input  resp_valid, resp_cmd, resp_dstaddr, resp_srcaddr, resp_data,
    output resp_ready
  );

  modport slave (
    input  req_valid, req_cmd, req_dstaddr, req_srcaddr, req_data,
    output req_ready,
    output resp_valid, resp_cmd, resp_dstaddr, resp_srcaddr, resp_data,
    input  resp_ready
  );
endinterface

// File: rtl/umi_regif_arb.sv
// rtl/umi_regif_arb.sv - N-host round-robin arbiter in front of one UMI register device
//
// Purpose: shares a single UMI device port among N hosts. Requests are
// granted round-robin (combinationally, same cycle) and a grant is held
// across multi-beat packets until eom. Every packet that expects a
// response records its host ID in an in-order tag FIFO; device responses
// are steered back to the host at the FIFO head.
//
// Ports:
//   clk          clock
//   nreset       asynchronous active-low reset
//   uhost        slave modport, NP=N: host requests in, responses out
//   udev         master modport, NP=1: muxed request out, device response in
//   err_spurious registered 1-cycle pulse: response arrived with no tag
//
// Optional build macro: UMI_REGIF_ARB_PRIO0_EN makes host 0 win whenever
// the port is unlocked and host 0 is eligible; host 0 packets leave the
// round-robin pointer untouched.
module umi_regif_arb #(
  parameter int N     = 2,
  parameter int CW    = 32,
  parameter int AW    = 64,
  parameter int DW    = 256,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            nreset,
  umi_regif_arb_if.slave  uhost,
  umi_regif_arb_if.master udev,
  output logic            err_spurious
);

  localparam int IW   = $clog2(N);
  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = PW + 1;
  localparam int EOM_BIT = 22;

  localparam logic [4:0] OP_READ   = 5'h01;
  localparam logic [4:0] OP_WRITE  = 5'h03;
  localparam logic [4:0] OP_ATOMIC = 5'h09;

  // arbitration state
  logic [IW-1:0]   rr_q, rr_d;
  logic            lock_q, lock_d;
  logic [IW-1:0]   lock_idx_q, lock_idx_d;

  // tag FIFO state
  logic [IW-1:0]   tags_q [DEPTH];
  logic [IW-1:0]   tags_d [DEPTH];
  logic [PW-1:0]   rd_q, rd_d;
  logic [PW-1:0]   wr_q, wr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            err_q, err_d;

  // combinational helpers
  logic [N-1:0]    needs_resp;
  logic [N-1:0]    req_eom;
  logic [N-1:0]    eligible;
  logic            fifo_full;
  logic            fifo_empty;
  logic [IW-1:0]   grant;
  logic [IW-1:0]   next_rr;
  logic            accept;
  logic            g_eom;
  logic            g_needs;
  logic            push;
  logic            pop;
  logic [IW-1:0]   head;

  assign fifo_full  = (count_q == CNTW'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign head       = tags_q[rd_q];

  // Per-host decode. A response-bearing request is held off while the tag
  // FIFO is full so a push can never overflow it.
  always_comb begin
    needs_resp = '0;
    req_eom    = '0;
    eligible   = '0;
    for (int i = 0; i < N; i++) begin
      needs_resp[i] = (uhost.req_cmd[i*CW +: 5] == OP_READ)  ||
                      (uhost.req_cmd[i*CW +: 5] == OP_WRITE) ||
                      (uhost.req_cmd[i*CW +: 5] == OP_ATOMIC);
      req_eom[i]    = uhost.req_cmd[i*CW + EOM_BIT];
      eligible[i]   = uhost.req_valid[i] && (!needs_resp[i] || !fifo_full);
    end
  end

  // Grant selection: first eligible index at or after rr_q, wrapping.
  // A locked packet owns the port even when its host is not eligible.
  always_comb begin
    int idx;
    logic found;
    grant = rr_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(rr_q) + k) % N;
      if (!found && eligible[idx]) begin
        grant = IW'(idx);
        found = 1'b1;
      end
    end
`ifdef UMI_REGIF_ARB_PRIO0_EN
    if (eligible[0]) begin
      grant = '0;
    end
`endif
    if (lock_q) begin
      grant = lock_idx_q;
    end
  end

  // Request mux and per-host ready.
  always_comb begin
    int gi;
    gi = int'(grant);
    udev.req_valid   = eligible[grant];
    udev.req_cmd     = uhost.req_cmd[gi*CW +: CW];
    udev.req_dstaddr = uhost.req_dstaddr[gi*AW +: AW];
    udev.req_srcaddr = uhost.req_srcaddr[gi*AW +: AW];
    udev.req_data    = uhost.req_data[gi*DW +: DW];
    uhost.req_ready  = '0;
    for (int i = 0; i < N; i++) begin
      uhost.req_ready[i] = udev.req_ready && (grant == IW'(i)) && eligible[i];
    end
  end

  assign accept  = udev.req_valid && udev.req_ready;
  assign g_eom   = req_eom[grant];
  assign g_needs = needs_resp[grant];
  assign next_rr = (grant == IW'(N-1)) ? '0 : grant + IW'(1);

  // Response steering: only the FIFO head sees valid. With no tag
  // outstanding the response is accepted and dropped.
  always_comb begin
    uhost.resp_valid = '0;
    for (int i = 0; i < N; i++) begin
      uhost.resp_valid[i] = udev.resp_valid && !fifo_empty && (head == IW'(i));
    end
    udev.resp_ready = fifo_empty ? 1'b1 : uhost.resp_ready[head];
  end

  assign uhost.resp_cmd     = udev.resp_cmd;
  assign uhost.resp_dstaddr = udev.resp_dstaddr;
  assign uhost.resp_srcaddr = udev.resp_srcaddr;
  assign uhost.resp_data    = udev.resp_data;

  assign push = accept && g_needs && g_eom;
  assign pop  = udev.resp_valid && udev.resp_ready && udev.resp_cmd[EOM_BIT] && !fifo_empty;

  // Next-state logic for arbitration and tag FIFO.
  always_comb begin
    rr_d       = rr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    tags_d     = tags_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    count_d    = count_q;
    err_d      = udev.resp_valid && fifo_empty;

    if (accept) begin
      if (!g_eom) begin
        lock_d     = 1'b1;
        lock_idx_d = grant;
      end else begin
        lock_d = 1'b0;
`ifdef UMI_REGIF_ARB_PRIO0_EN
        // host 0 rides above the rotation and does not advance it
        if (grant != '0) begin
          rr_d = next_rr;
        end
`else
        rr_d = next_rr;
`endif
      end
    end

    if (push) begin
      tags_d[wr_q] = grant;
      wr_d         = wr_q + PW'(1);
    end
    if (pop) begin
      rd_d = rd_q + PW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNTW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        tags_q[i] <= '0;
      end
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      count_q    <= count_d;
      err_q      <= err_d;
      tags_q     <= tags_d;
    end
  end

  assign err_spurious = err_q;

endmodule

// File: tb/tb_umi_regif_arb.sv
// tb/tb_umi_regif_arb.sv - scoreboard bench for umi_regif_arb (N=4, DEPTH=4)
module tb_umi_regif_arb;

  localparam int N  = 4;
  localparam logic [4:0] OP_READ   = 5'h01;
  localparam logic [4:0] OP_WRITE  = 5'h03;
  localparam logic [4:0] OP_POSTED = 5'h05;

  localparam int K_RDY    = 0;
  localparam int K_DVALID = 1;
  localparam int K_URRDY  = 2;
  localparam int K_RVALID = 3;
  localparam int K_ERR    = 4;
  localparam int K_TMO    = 5;

  logic clk;
  logic nreset;
  logic err_spurious;

  umi_regif_arb_if #(.NP(N)) uhost ();
  umi_regif_arb_if #(.NP(1)) udev ();

  umi_regif_arb #(.N(N), .DEPTH(4)) dut (
    .clk          (clk),
    .nreset       (nreset),
    .uhost        (uhost),
    .udev         (udev),
    .err_spurious (err_spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [63:0] exp;
    logic [63:0] tbv;
  } chk_t;

  // host / device model state (owned by the stimulus process)
  int          hcnt [N];
  logic [4:0]  hop  [N];
  bit          multi[N];
  logic [3:0]  hrdy;
  bit          auto_resp;
  bit          force_spur;
  logic        dreq_ready;
  int          tno;
  logic [63:0] pend[$];

  // scoreboard queues (pushed by stimulus, popped by monitor)
  logic [63:0] exp_req[$];
  logic [63:0] exp_resp[$];
  chk_t        chk_q[$];
  bit          done;

  int tests;
  int fails;

  function automatic logic [63:0] addr(input int t, input int h);
    return 64'(t * 256 + h);
  endfunction

  task automatic push_chk(input int kind, input logic [63:0] exp, input logic [63:0] tbv = '0);
    chk_t c;
    c.kind = kind;
    c.exp  = exp;
    c.tbv  = tbv;
    chk_q.push_back(c);
  endtask

  task automatic expect_pkt(input int t, input int h, input bit resp);
    exp_req.push_back(addr(t, h));
    if (resp) exp_resp.push_back(addr(t, h));
  endtask

  task automatic drive();
    logic eom;
    for (int i = 0; i < N; i++) begin
      eom = !multi[i] || (hcnt[i] == 1);
      uhost.req_valid[i]             = (hcnt[i] > 0);
      uhost.req_cmd[i*32 +: 32]      = (32'(eom) << 22) | 32'(hop[i]);
      uhost.req_dstaddr[i*64 +: 64]  = addr(tno, i);
      uhost.req_srcaddr[i*64 +: 64]  = 64'(i);
      uhost.req_data[i*256 +: 256]   = 256'(addr(tno, i));
    end
    uhost.resp_ready  = hrdy;
    udev.req_ready    = dreq_ready;
    udev.resp_valid   = force_spur || (auto_resp && pend.size() > 0);
    udev.resp_cmd     = 32'h0040_0000;
    udev.resp_dstaddr = '0;
    udev.resp_srcaddr = '0;
    if (pend.size() > 0) udev.resp_data = 256'(pend[0]);
    else                 udev.resp_data = 256'hdead;
  endtask

  // One clock: sample handshakes away from the edge, update host and
  // device models after the edge, then re-drive inputs.
  task automatic step();
    logic [N-1:0] hacc;
    logic         rhs, dacc, dneed;
    logic [63:0]  daddr;
    @(negedge clk);
    hacc  = uhost.req_valid & uhost.req_ready;
    rhs   = udev.resp_valid & udev.resp_ready;
    dacc  = udev.req_valid & udev.req_ready;
    daddr = udev.req_dstaddr;
    dneed = udev.req_cmd[22] && (udev.req_cmd[4:0] inside {5'h01, 5'h03, 5'h09});
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (hacc[i] && hcnt[i] > 0) hcnt[i]--;
    if (rhs && pend.size() > 0) void'(pend.pop_front());
    if (dacc && dneed) pend.push_back(daddr);
    drive();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((hcnt[0] + hcnt[1] + hcnt[2] + hcnt[3] > 0 || pend.size() > 0) && n < 60) begin
      step();
      n++;
    end
    push_chk(K_TMO, 64'd0, 64'(n >= 60));
    step();
    step();
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares everything the DUT presents against the scoreboard.
  initial begin : monitor
    chk_t        c;
    logic [63:0] e;
    int          cyc;
    tests = 0;
    fails = 0;
    cyc   = 0;
    forever begin
      @(negedge clk);
      cyc++;
      while (chk_q.size() > 0) begin
        c = chk_q.pop_front();
        case (c.kind)
          K_RDY:    check("host_req_ready", 64'(uhost.req_ready), c.exp);
          K_DVALID: check("dev_req_valid", 64'(udev.req_valid), c.exp);
          K_URRDY:  check("dev_resp_ready", 64'(udev.resp_ready), c.exp);
          K_RVALID: check("host_resp_valid", 64'(uhost.resp_valid), c.exp);
          K_ERR:    check("err_spurious", 64'(err_spurious), c.exp);
          default:  check("drain_timeout", c.tbv, c.exp);
        endcase
      end
      if (udev.req_valid && udev.req_ready) begin
        if (exp_req.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL req_extra: got dstaddr %0h expected no request", udev.req_dstaddr);
        end else begin
          e = exp_req.pop_front();
          check("req_order", udev.req_dstaddr, e);
        end
      end
      for (int i = 0; i < N; i++) begin
        if (uhost.resp_valid[i] && uhost.resp_ready[i]) begin
          if (exp_resp.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL resp_extra: got host %0d expected no response", i);
          end else begin
            e = exp_resp.pop_front();
            check("resp_host", 64'(i), 64'(e[7:0]));
            check("resp_data", uhost.resp_data[63:0], e);
          end
        end
      end
      if (done) begin
        check("req_left", 64'(exp_req.size()), 64'd0);
        check("resp_left", 64'(exp_resp.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
      end
      if (cyc > 5000) begin
        tests++;
        fails++;
        $display("FAIL sim_timeout: got %0d cycles expected completion", cyc);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
      end
    end
  end

  initial begin : stim
    done       = 1'b0;
    nreset     = 1'b0;
    tno        = 0;
    hrdy       = 4'hf;
    auto_resp  = 1'b0;
    force_spur = 1'b0;
    dreq_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      hcnt[i]  = 0;
      hop[i]   = OP_READ;
      multi[i] = 1'b0;
    end
    drive();
    step();
    push_chk(K_DVALID, 64'd0);
    push_chk(K_RDY, 64'd0);
    push_chk(K_RVALID, 64'd0);
    push_chk(K_ERR, 64'd0);
    step();
    nreset     = 1'b1;
    dreq_ready = 1'b1;
    auto_resp  = 1'b1;
    drive();
    step();

    // 1: all hosts stream single-beat READs -> 0,1,2,3,0,1,2,3
    tno = 1;
    for (int i = 0; i < N; i++) begin
      hop[i]  = OP_READ;
      hcnt[i] = 2;
    end
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) expect_pkt(1, i, 1'b1);
    drive();
    drain();

    // 2: host1 3-beat WRITE holds the port; then rr points at host2
    tno = 2;
    hop[1] = OP_WRITE; multi[1] = 1'b1; hcnt[1] = 3;
    hop[2] = OP_READ;  hcnt[2] = 1;
    exp_req.push_back(addr(2, 1));
    exp_req.push_back(addr(2, 1));
    expect_pkt(2, 1, 1'b1);
    expect_pkt(2, 2, 1'b1);
    expect_pkt(2, 0, 1'b1);
    drive();
    step();
    hop[0] = OP_READ; hcnt[0] = 1; dreq_ready = 1'b0;
    drive();
    push_chk(K_DVALID, 64'd1);
    push_chk(K_RDY, 64'd0);
    step();
    dreq_ready = 1'b1; drive();
    push_chk(K_RDY, 64'b0010);
    step();
    dreq_ready = 1'b0; drive();
    push_chk(K_RDY, 64'd0);
    push_chk(K_DVALID, 64'd1);
    step();
    dreq_ready = 1'b1; drive();
    push_chk(K_RDY, 64'b0010);
    step();
    push_chk(K_RDY, 64'b0100);
    drain();
    multi[1] = 1'b0;

    // 3: four READs fill the tag FIFO; POSTED still passes; pop frees slot next cycle
    tno = 3;
    auto_resp = 1'b0;
    hop[1] = OP_READ; hcnt[1] = 5;
    for (int r = 0; r < 4; r++) expect_pkt(3, 1, 1'b1);
    expect_pkt(3, 3, 1'b0);
    expect_pkt(3, 1, 1'b1);
    drive();
    repeat (4) step();
    hop[3] = OP_POSTED; hcnt[3] = 1;
    drive();
    push_chk(K_RDY, 64'b1000);
    push_chk(K_DVALID, 64'd1);
    step();
    auto_resp = 1'b1;
    drive();
    push_chk(K_RDY, 64'd0);
    push_chk(K_DVALID, 64'd0);
    push_chk(K_RVALID, 64'b0010);
    step();
    push_chk(K_RDY, 64'b0010);
    drain();

    // 4: head host (2) stalls its response for 5 cycles; host0 waits behind it
    tno = 4;
    auto_resp = 1'b0;
    hop[0] = OP_READ; hop[2] = OP_READ;
    hcnt[0] = 1; hcnt[2] = 1;
    expect_pkt(4, 2, 1'b1);
    expect_pkt(4, 0, 1'b1);
    drive();
    step();
    step();
    hrdy = 4'b1011; auto_resp = 1'b1;
    drive();
    repeat (5) begin
      push_chk(K_URRDY, 64'd0);
      push_chk(K_RVALID, 64'b0100);
      step();
    end
    hrdy = 4'hf;
    drive();
    push_chk(K_URRDY, 64'd1);
    push_chk(K_RVALID, 64'b0100);
    drain();

    // 5: response with empty FIFO is dropped and flagged one cycle later
    tno = 5;
    auto_resp = 1'b0; force_spur = 1'b1;
    drive();
    push_chk(K_URRDY, 64'd1);
    push_chk(K_RVALID, 64'd0);
    push_chk(K_ERR, 64'd0);
    step();
    force_spur = 1'b0;
    drive();
    push_chk(K_ERR, 64'd1);
    step();
    push_chk(K_ERR, 64'd0);
    step();

    // 6: hosts 0 and 2 contend continuously
    tno = 6;
    auto_resp = 1'b1;
    hop[0] = OP_READ; hop[2] = OP_READ;
    hcnt[0] = 3; hcnt[2] = 3;
`ifdef UMI_REGIF_ARB_PRIO0_EN
    for (int r = 0; r < 3; r++) expect_pkt(6, 0, 1'b1);
    for (int r = 0; r < 3; r++) expect_pkt(6, 2, 1'b1);
`else
    for (int r = 0; r < 3; r++) begin
      expect_pkt(6, 2, 1'b1);
      expect_pkt(6, 0, 1'b1);
    end
`endif
    drive();
    drain();

    // 7: reset with a tag outstanding and a packet locked
    tno = 7;
    auto_resp = 1'b0;
    hop[1] = OP_READ; hcnt[1] = 1;
    exp_req.push_back(addr(7, 1));
    drive();
    step();
    hop[3] = OP_WRITE; multi[3] = 1'b1; hcnt[3] = 3;
    exp_req.push_back(addr(7, 3));
    drive();
    step();
    nreset = 1'b0; hcnt[3] = 0; multi[3] = 1'b0;
    drive();
    step();
    nreset = 1'b1; auto_resp = 1'b1;
    drive();
    push_chk(K_URRDY, 64'd1);
    push_chk(K_RVALID, 64'd0);
    step();
    push_chk(K_ERR, 64'd1);
    hop[3] = OP_READ; hcnt[0] = 1; hcnt[3] = 1;
    expect_pkt(7, 0, 1'b1);
    expect_pkt(7, 3, 1'b1);
    drive();
    push_chk(K_RDY, 64'b0001);
    drain();

    done = 1'b1;
    repeat (20) @(posedge clk);
  end

endmodule
